// File: rtl/mem_dump_reader.sv
// Debug-side memory dump reader: walks a word-address range of the data memory
// and streams each word as four bytes, MSB first, over a valid/ready interface.
module mem_dump_reader #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_first_addr,
  input  logic [NB_ADDR:0]   i_word_count,
  input  logic               i_abort,
  output logic [NB_ADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0] i_mem_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_ADDR:0]   r_count;
  logic [1:0]         r_byte_idx;
  logic [NB_DATA-1:0] r_shift;
  logic               r_done_zero;

  logic w_start_ok;
  logic w_hs;
  logic w_last_byte;
  logic w_last_word;

  assign w_start_ok  = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_hs        = (r_state == ST_SEND) && i_tx_ready;
  assign w_last_byte = w_hs && (r_byte_idx == 2'd3);
  // r_count holds the words still to send, including the one in flight
  assign w_last_word = (r_count == {{NB_ADDR{1'b0}}, 1'b1});

  assign o_mem_addr = r_addr;
  assign o_tx_data  = r_shift[NB_DATA-1 -: NB_BYTE];

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; abort overrides every transition
  always_comb begin
    w_next_state = r_state;
    o_tx_valid   = 1'b0;
    o_busy       = 1'b1;
    o_done       = r_done_zero;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (w_start_ok && (i_word_count != '0)) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        if (w_last_byte) begin
          w_next_state = w_last_word ? ST_IDLE : ST_LOAD;
          o_done       = w_last_word && !i_abort;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (i_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // Address, word counter, byte index and shift register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_count     <= '0;
      r_byte_idx  <= 2'd0;
      r_shift     <= '0;
      r_done_zero <= 1'b0;
    end else begin
      r_done_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            if (i_word_count != '0) begin
              r_count <= i_word_count;
              r_addr  <= i_first_addr;
            end else begin
              r_done_zero <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_shift    <= i_mem_data;
          r_byte_idx <= 2'd0;
        end
        ST_SEND: begin
          if (w_hs) begin
            r_shift    <= {r_shift[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte && !w_last_word && !i_abort) begin
              r_addr  <= r_addr + {{(NB_ADDR-1){1'b0}}, 1'b1};
              r_count <= r_count - {{NB_ADDR{1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          r_byte_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule
